// File: rtl/alu_op_sequencer.sv
// Initiator for the 2-bit ALU: registers each command onto A/B/S, captures O one
// cycle later and queues {select, result} in a first-word fall-through FIFO.
module alu_op_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_a,
    input  logic [1:0]       cmd_b,
    input  logic [1:0]       cmd_sel,
    output logic [1:0]       alu_a,
    output logic [1:0]       alu_b,
    output logic [1:0]       alu_s,
    input  logic [3:0]       alu_o,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_data,
    output logic [1:0]       res_sel,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    typedef enum logic {IDLE, CAPT} state_t;
    state_t state, state_nxt;

    logic [5:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             accept, push, pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // cmd_ready depends only on registered state, so a pop shows up one cycle later
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = (count < FULL);
                if (cmd_valid && (count < FULL)) state_nxt = CAPT;
            end
            CAPT: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept    = cmd_valid && cmd_ready;
    assign push      = (state == CAPT);
    assign res_valid = (count != '0);
    assign pop       = res_valid && res_ready;
    assign res_data  = mem[rd_ptr][3:0];
    assign res_sel   = mem[rd_ptr][5:4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_s    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            done_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (accept) begin
                alu_a <= cmd_a;
                alu_b <= cmd_b;
                alu_s <= cmd_sel;
            end
            // Only one command is ever in flight, so a push cannot find the FIFO full
            if (push) begin
                mem[wr_ptr] <= {alu_s, alu_o};
                wr_ptr      <= wr_ptr + PTR_W'(1);
                done_cnt    <= done_cnt + CNT_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
